video_scaler_nx: RTL and testbench

- Parametrised successor to the power-of-two video scaler.
- Contains its own VGA timing counters and divides the visible raster by arbitrary, independent integer factors per axis (HSCALE, VSCALE ≥ 1, not restricted to powers of two).
- Produces logical pixel coordinates plus pixel, line and frame strobes, so framebuffer/tile readers fetch once per logical pixel.
- Sits between the pixel clock domain and the video memory fetch logic.

---
 rtl/video_scaler_nx.sv | 170 +++++++++++++++++
 tb/tb_video_scaler_nx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/video_scaler_nx.sv
// VGA raster generator with independent integer down-scaling per axis (logical pixel coords + strobes).
// Optional VIDEO_SCALER_LOOKAHEAD_EN: hpos/vpos/pix_stb/line_stb lead the other outputs by one clock.
module video_scaler_nx #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_NEG  = 1,
    parameter int HSCALE    = 4,
    parameter int VSCALE    = 4,
    localparam int H_LOG    = (H_DISPLAY + HSCALE - 1) / HSCALE,
    localparam int V_LOG    = (V_DISPLAY + VSCALE - 1) / VSCALE,
    localparam int HW       = (H_LOG > 1) ? $clog2(H_LOG) : 1,
    localparam int VW       = (V_LOG > 1) ? $clog2(V_LOG) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic          hsync,
    output logic          vsync,
    output logic          display_on,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic          pix_stb,
    output logic          line_stb,
    output logic          frame_stb
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    // One spare bit so the sync end boundary is representable even with a zero back porch
    localparam int HCW = $clog2(H_TOTAL + 1);
    localparam int VCW = $clog2(V_TOTAL + 1);
    localparam int HSW = (HSCALE > 1) ? $clog2(HSCALE) : 1;
    localparam int VSW = (VSCALE > 1) ? $clog2(VSCALE) : 1;

    localparam logic [HCW-1:0] H_LAST    = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] V_LAST    = VCW'(V_TOTAL - 1);
    localparam logic [HCW-1:0] H_DISP_C  = HCW'(H_DISPLAY);
    localparam logic [VCW-1:0] V_DISP_C  = VCW'(V_DISPLAY);
    localparam logic [HCW-1:0] HS_BEG    = HCW'(H_DISPLAY + H_FRONT);
    localparam logic [HCW-1:0] HS_END    = HCW'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [VCW-1:0] VS_BEG    = VCW'(V_DISPLAY + V_FRONT);
    localparam logic [VCW-1:0] VS_END    = VCW'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [HSW-1:0] HSUB_LAST = HSW'(HSCALE - 1);
    localparam logic [VSW-1:0] VSUB_LAST = VSW'(VSCALE - 1);
    localparam logic [HW-1:0]  HPOS_LAST = HW'(H_LOG - 1);
    localparam logic [VW-1:0]  VPOS_LAST = VW'(V_LOG - 1);
    localparam logic           SYNC_INACT = (SYNC_NEG != 0);

    logic [HCW-1:0] r_hcnt, w_hcnt_nxt, w_f_hcnt;
    logic [VCW-1:0] r_vcnt, w_vcnt_nxt, w_f_vcnt;
    logic [HSW-1:0] r_hsub, w_hsub_nxt, w_f_hsub;
    logic [VSW-1:0] r_vsub, w_vsub_nxt, w_f_vsub;
    logic [HW-1:0]  r_hpos, w_hpos_nxt, w_f_hpos;
    logic [VW-1:0]  r_vpos, w_vpos_nxt, w_f_vpos;
    logic           w_line_end, w_frame_end;
    logic           w_de, w_hs_act, w_vs_act, w_ps, w_ls, w_fs;

    always_comb begin
        w_line_end  = (r_hcnt == H_LAST);
        w_frame_end = w_line_end && (r_vcnt == V_LAST);

        w_hcnt_nxt = w_line_end ? '0 : r_hcnt + HCW'(1);
        w_vcnt_nxt = r_vcnt;
        if (w_frame_end)
            w_vcnt_nxt = '0;
        else if (w_line_end)
            w_vcnt_nxt = r_vcnt + VCW'(1);

        // Positions saturate at the last logical index so truncated edge pixels/rows never overflow
        w_hsub_nxt = r_hsub;
        w_hpos_nxt = r_hpos;
        if (w_line_end) begin
            w_hsub_nxt = '0;
            w_hpos_nxt = '0;
        end else if (r_hcnt < H_DISP_C) begin
            if (r_hsub == HSUB_LAST) begin
                w_hsub_nxt = '0;
                if (r_hpos != HPOS_LAST)
                    w_hpos_nxt = r_hpos + HW'(1);
            end else begin
                w_hsub_nxt = r_hsub + HSW'(1);
            end
        end

        w_vsub_nxt = r_vsub;
        w_vpos_nxt = r_vpos;
        if (w_frame_end) begin
            w_vsub_nxt = '0;
            w_vpos_nxt = '0;
        end else if (w_line_end && (r_vcnt < V_DISP_C)) begin
            if (r_vsub == VSUB_LAST) begin
                w_vsub_nxt = '0;
                if (r_vpos != VPOS_LAST)
                    w_vpos_nxt = r_vpos + VW'(1);
            end else begin
                w_vsub_nxt = r_vsub + VSW'(1);
            end
        end
    end

`ifdef VIDEO_SCALER_LOOKAHEAD_EN
    assign w_f_hcnt = w_hcnt_nxt;
    assign w_f_vcnt = w_vcnt_nxt;
    assign w_f_hsub = w_hsub_nxt;
    assign w_f_vsub = w_vsub_nxt;
    assign w_f_hpos = w_hpos_nxt;
    assign w_f_vpos = w_vpos_nxt;
`else
    assign w_f_hcnt = r_hcnt;
    assign w_f_vcnt = r_vcnt;
    assign w_f_hsub = r_hsub;
    assign w_f_vsub = r_vsub;
    assign w_f_hpos = r_hpos;
    assign w_f_vpos = r_vpos;
`endif

    always_comb begin
        w_de     = (r_hcnt < H_DISP_C) && (r_vcnt < V_DISP_C);
        w_hs_act = (r_hcnt >= HS_BEG) && (r_hcnt < HS_END);
        w_vs_act = (r_vcnt >= VS_BEG) && (r_vcnt < VS_END);
        w_fs     = (r_hcnt == '0) && (r_vcnt == '0);
        w_ps     = (w_f_hcnt < H_DISP_C) && (w_f_vcnt < V_DISP_C) && (w_f_hsub == '0);
        w_ls     = (w_f_hcnt == '0) && (w_f_vcnt < V_DISP_C) && (w_f_vsub == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
            r_hsub <= '0;
            r_vsub <= '0;
            r_hpos <= '0;
            r_vpos <= '0;
        end else begin
            r_hcnt <= w_hcnt_nxt;
            r_vcnt <= w_vcnt_nxt;
            r_hsub <= w_hsub_nxt;
            r_vsub <= w_vsub_nxt;
            r_hpos <= w_hpos_nxt;
            r_vpos <= w_vpos_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync      <= SYNC_INACT;
            vsync      <= SYNC_INACT;
            display_on <= 1'b0;
            hpos       <= '0;
            vpos       <= '0;
            pix_stb    <= 1'b0;
            line_stb   <= 1'b0;
            frame_stb  <= 1'b0;
        end else begin
            hsync      <= w_hs_act ^ SYNC_INACT;
            vsync      <= w_vs_act ^ SYNC_INACT;
            display_on <= w_de;
            hpos       <= w_f_hpos;
            vpos       <= w_f_vpos;
            pix_stb    <= w_ps;
            line_stb   <= w_ls;
            frame_stb  <= w_fs;
        end
    end

endmodule

// File: tb/tb_video_scaler_nx.sv
// Self-checking bench for video_scaler_nx: four parameterisations checked every cycle against an
// arithmetic raster model, including an asynchronous mid-frame reset and frame-period measurement.
module tb_video_scaler_nx;
    localparam int SHD = 20, SHF = 3, SHS = 4, SHB = 5;
    localparam int SVD = 14, SVF = 2, SVS = 2, SVB = 3;
    localparam int S_FT = (SHD + SHF + SHS + SHB) * (SVD + SVF + SVS + SVB);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    logic a_hs, a_vs, a_de, a_ps, a_ls, a_fs;
    logic [2:0] a_hp;
    logic [1:0] a_vp;
    logic b_hs, b_vs, b_de, b_ps, b_ls, b_fs;
    logic [4:0] b_hp;
    logic [3:0] b_vp;
    logic c_hs, c_vs, c_de, c_ps, c_ls, c_fs;
    logic [7:0] c_hp;
    logic [6:0] c_vp;
    logic d_hs, d_vs, d_de, d_ps, d_ls, d_fs;
    logic [2:0] d_hp;
    logic [1:0] d_vp;

    // Non-divisible scaling (20/3, 14/5) on a small raster
    video_scaler_nx #(
        .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .SYNC_NEG(1), .HSCALE(3), .VSCALE(5)
    ) u_a (
        .clk(clk), .reset_n(reset_n), .hsync(a_hs), .vsync(a_vs), .display_on(a_de),
        .hpos(a_hp), .vpos(a_vp), .pix_stb(a_ps), .line_stb(a_ls), .frame_stb(a_fs)
    );

    // Unity scaling with active-high sync
    video_scaler_nx #(
        .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .SYNC_NEG(0), .HSCALE(1), .VSCALE(1)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .hsync(b_hs), .vsync(b_vs), .display_on(b_de),
        .hpos(b_hp), .vpos(b_vp), .pix_stb(b_ps), .line_stb(b_ls), .frame_stb(b_fs)
    );

    // Default 640x480 timing, only the first lines are reachable in the cycle budget
    video_scaler_nx u_c (
        .clk(clk), .reset_n(reset_n), .hsync(c_hs), .vsync(c_vs), .display_on(c_de),
        .hpos(c_hp), .vpos(c_vp), .pix_stb(c_ps), .line_stb(c_ls), .frame_stb(c_fs)
    );

    // Exact horizontal division, truncated last row vertically (14/4)
    video_scaler_nx #(
        .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .SYNC_NEG(1), .HSCALE(4), .VSCALE(4)
    ) u_d (
        .clk(clk), .reset_n(reset_n), .hsync(d_hs), .vsync(d_vs), .display_on(d_de),
        .hpos(d_hp), .vpos(d_vp), .pix_stb(d_ps), .line_stb(d_ls), .frame_stb(d_fs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected outputs for the c-th counter state after reset release, from raster arithmetic
    task automatic chk_model(input string nm,
                             input int hd, input int hf, input int hsy, input int hb,
                             input int vd, input int vf, input int vsy, input int vb,
                             input int sn, input int hsc, input int vsc, input int c,
                             input logic hs, input logic vs, input logic de,
                             input logic [31:0] hp, input logic [31:0] vp,
                             input logic ps, input logic ls, input logic fs);
        int ht, vt, h, v, hlog, vlog;
        logic vis, hact, vact;
        ht   = hd + hf + hsy + hb;
        vt   = vd + vf + vsy + vb;
        h    = c % ht;
        v    = (c / ht) % vt;
        hlog = (hd + hsc - 1) / hsc;
        vlog = (vd + vsc - 1) / vsc;
        vis  = (h < hd) && (v < vd);
        hact = (h >= hd + hf) && (h < hd + hf + hsy);
        vact = (v >= vd + vf) && (v < vd + vf + vsy);
        chk({nm, ".hsync"},      32'(hs), 32'((sn != 0) ? !hact : hact));
        chk({nm, ".vsync"},      32'(vs), 32'((sn != 0) ? !vact : vact));
        chk({nm, ".display_on"}, 32'(de), 32'(vis));
        chk({nm, ".hpos"},       hp,      32'((h < hd) ? h / hsc : hlog - 1));
        chk({nm, ".vpos"},       vp,      32'((v < vd) ? v / vsc : vlog - 1));
        chk({nm, ".pix_stb"},    32'(ps), 32'(vis && (h % hsc == 0)));
        chk({nm, ".line_stb"},   32'(ls), 32'((h == 0) && (v < vd) && (v % vsc == 0)));
        chk({nm, ".frame_stb"},  32'(fs), 32'((h == 0) && (v == 0)));
    endtask

    task automatic chk_reset(input string nm, input int sn,
                             input logic hs, input logic vs, input logic de,
                             input logic [31:0] hp, input logic [31:0] vp,
                             input logic ps, input logic ls, input logic fs);
        chk({nm, ".rst_hsync"},      32'(hs), 32'(sn != 0));
        chk({nm, ".rst_vsync"},      32'(vs), 32'(sn != 0));
        chk({nm, ".rst_display_on"}, 32'(de), 32'(0));
        chk({nm, ".rst_hpos"},       hp,      32'(0));
        chk({nm, ".rst_vpos"},       vp,      32'(0));
        chk({nm, ".rst_pix_stb"},    32'(ps), 32'(0));
        chk({nm, ".rst_line_stb"},   32'(ls), 32'(0));
        chk({nm, ".rst_frame_stb"},  32'(fs), 32'(0));
    endtask

    task automatic check_all(input int c);
        chk_model("a", SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB, 1, 3, 5, c,
                  a_hs, a_vs, a_de, 32'(a_hp), 32'(a_vp), a_ps, a_ls, a_fs);
        chk_model("b", SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB, 0, 1, 1, c,
                  b_hs, b_vs, b_de, 32'(b_hp), 32'(b_vp), b_ps, b_ls, b_fs);
        chk_model("c", 640, 16, 96, 48, 480, 10, 2, 33, 1, 4, 4, c,
                  c_hs, c_vs, c_de, 32'(c_hp), 32'(c_vp), c_ps, c_ls, c_fs);
        chk_model("d", SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB, 1, 4, 4, c,
                  d_hs, d_vs, d_de, 32'(d_hp), 32'(d_vp), d_ps, d_ls, d_fs);
    endtask

    task automatic reset_all();
        chk_reset("a", 1, a_hs, a_vs, a_de, 32'(a_hp), 32'(a_vp), a_ps, a_ls, a_fs);
        chk_reset("b", 0, b_hs, b_vs, b_de, 32'(b_hp), 32'(b_vp), b_ps, b_ls, b_fs);
        chk_reset("c", 1, c_hs, c_vs, c_de, 32'(c_hp), 32'(c_vp), c_ps, c_ls, c_fs);
        chk_reset("d", 1, d_hs, d_vs, d_de, 32'(d_hp), 32'(d_vp), d_ps, d_ls, d_fs);
    endtask

    initial begin
        int cnt;
        int off;
        int fidx;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_all();

        // Release on a falling edge; the next rising edge registers state (0,0)
        reset_n = 1'b1;
        cnt = 0;
        off = int'($urandom_range(600, 100));
        for (int k = 0; k < 2 * S_FT + off; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_all(cnt);
            cnt++;
        end

        // Asynchronous assertion between clock edges must clear outputs immediately
        #2 reset_n = 1'b0;
        #1 reset_all();
        repeat (3) begin
            @(negedge clk);
            reset_all();
        end
        reset_n = 1'b1;

        cnt  = 0;
        fidx = -1;
        for (int k = 0; k < S_FT + 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_all(cnt);
            if (a_fs === 1'b1 && k > 0 && fidx < 0)
                fidx = k;
            cnt++;
        end
        chk("frame_period", 32'(fidx), 32'(S_FT));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
